// File: rtl/alu_seq.sv
// Sequential ALU with a ready/valid handshake. Most ops finish in one cycle.
// MUL/MULHU use shift-add and DIVU/REMU use restoring division, one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000, OP_SUB  = 4'b0001, OP_AND   = 4'b0010, OP_OR   = 4'b0011,
    OP_NOR   = 4'b0100, OP_XOR  = 4'b0101, OP_SLT   = 4'b0110, OP_SLTU = 4'b0111,
    OP_SLL   = 4'b1000, OP_SRL  = 4'b1001, OP_SRA   = 4'b1010, OP_MUL  = 4'b1011,
    OP_MULHU = 4'b1100, OP_DIVU = 4'b1101, OP_REMU  = 4'b1110, OP_ADD2 = 4'b1111
  } op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state;
  op_e              op_r;
  op_e              op_in;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] acc;   // product high half / partial remainder
  logic [WIDTH-1:0] lo;    // multiplier shifting out / dividend-to-quotient
  logic [CNT_W-1:0] cnt;

  assign op_in     = op_e'(ALU_ctrl);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Single-cycle datapath, evaluated on the live inputs at accept time.
  logic [WIDTH-1:0] sum, dif, alu_res;
  logic [SH_W-1:0]  sh;
  logic             alu_ovf, is_mul, is_iter;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sum     = A + B;
    dif     = A - B;
    sh      = B[SH_W-1:0];
    alu_res = sum;
    alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    case (op_in)
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  begin alu_res = A & B;    alu_ovf = 1'b0; end
      OP_OR:   begin alu_res = A | B;    alu_ovf = 1'b0; end
      OP_NOR:  begin alu_res = ~(A | B); alu_ovf = 1'b0; end
      OP_XOR:  begin alu_res = A ^ B;    alu_ovf = 1'b0; end
      OP_SLT:  begin alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)}; alu_ovf = 1'b0; end
      OP_SLTU: begin alu_res = {{(WIDTH-1){1'b0}}, A < B}; alu_ovf = 1'b0; end
      OP_SLL:  begin alu_res = A << sh;  alu_ovf = 1'b0; end
      OP_SRL:  begin alu_res = A >> sh;  alu_ovf = 1'b0; end
      OP_SRA:  begin alu_res = $unsigned($signed(A) >>> sh); alu_ovf = 1'b0; end
      // Divide-by-zero values; taken only when B is zero.
      OP_DIVU: begin alu_res = '1;       alu_ovf = 1'b0; end
      OP_REMU: begin alu_res = A;        alu_ovf = 1'b0; end
      OP_MUL, OP_MULHU: begin alu_res = '0; alu_ovf = 1'b0; end
      default: ;
    endcase
    is_mul  = (op_in == OP_MUL) || (op_in == OP_MULHU);
    is_iter = is_mul || (((op_in == OP_DIVU) || (op_in == OP_REMU)) && (B != '0));
  end

  // One iteration step of the multiplier or divider.
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0] it_acc, it_lo, it_res;

  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, a_r} : '0);
    div_shift = {acc, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_r};
    if ((op_r == OP_MUL) || (op_r == OP_MULHU)) begin
      it_acc = mul_sum[WIDTH:1];
      it_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      it_acc = div_diff[WIDTH-1:0];
      it_lo  = {lo[WIDTH-2:0], 1'b1};
    end else begin
      it_acc = div_shift[WIDTH-1:0];
      it_lo  = {lo[WIDTH-2:0], 1'b0};
    end
    it_res = ((op_r == OP_MUL) || (op_r == OP_DIVU)) ? it_lo : it_acc;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_r   <= OP_ADD;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
      zero   <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_r <= op_in;
            a_r  <= A;
            b_r  <= B;
            acc  <= '0;
            lo   <= is_mul ? B : A;
            cnt  <= '0;
            if (is_iter) begin
              state <= BUSY;
            end else begin
              result <= alu_res;
              zero   <= (alu_res == '0);
              ovf    <= alu_ovf;
              state  <= DONE;
            end
          end
        end
        BUSY: begin
          acc <= it_acc;
          lo  <= it_lo;
          if (cnt == CNT_LAST) begin
            result <= it_res;
            zero   <= (it_res == '0);
            ovf    <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: single-cycle ops, multi-cycle
// mul/div timing, divide by zero, backpressure and reset mid-operation.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, result;
  logic [3:0]    ALU_ctrl;
  logic          zero, ovf;

  int total = 0;
  int bad   = 0;
  int ready_leak;

  alu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_ctrl(ALU_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [31:0] a, b, r;
    logic       z, o;
    int         lat;
  } vec_t;

  // Issue one op, scramble inputs after accept, wait (bounded) for out_valid,
  // sample outputs, then complete the handshake. lat = -1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic o,
                        output int lat);
    @(negedge clk);
    A = a; B = b; ALU_ctrl = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; B = ~b; ALU_ctrl = ~op;
    lat = 1;
    ready_leak = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_leak++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    res = result; z = zero; o = ovf;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", result); end
    total++; if (zero !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags: got z=%b o=%b want z=1 o=0", zero, ovf); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic run_table(input vec_t v[]);
    logic [31:0] r; logic z, o; int lat;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, r, z, o, lat);
      total++; if (r !== v[i].r) begin bad++; $display("FAIL %s result: got %h want %h", v[i].name, r, v[i].r); end
      total++; if (z !== v[i].z || o !== v[i].o) begin bad++; $display("FAIL %s flags: got z=%b o=%b want z=%b o=%b", v[i].name, z, o, v[i].z, v[i].o); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL %s latency: got %0d want %0d", v[i].name, lat, v[i].lat); end
      total++; if (ready_leak !== 0) begin bad++; $display("FAIL %s in_ready_busy: got %0d cycles high want 0", v[i].name, ready_leak); end
    end
  endtask

  task automatic test_single();
    vec_t v[] = '{
      '{"add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1},
      '{"add_wrap", 4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1},
      '{"sub_zero", 4'b0001, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0, 1},
      '{"sub_ovf",  4'b0001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1},
      '{"and",      4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0, 1},
      '{"or",       4'b0011, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1},
      '{"nor",      4'b0100, 32'h0,          32'h0,      32'hFFFFFFFF, 1'b0, 1'b0, 1},
      '{"xor",      4'b0101, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1},
      '{"slt",      4'b0110, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0, 1},
      '{"sltu",     4'b0111, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0, 1},
      '{"sll",      4'b1000, 32'h1,        32'h1F,       32'h80000000, 1'b0, 1'b0, 1},
      '{"sll_mask", 4'b1000, 32'h1,        32'h21,       32'h2,        1'b0, 1'b0, 1},
      '{"srl",      4'b1001, 32'h80000000, 32'h1F,       32'h1,        1'b0, 1'b0, 1},
      '{"sra",      4'b1010, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0, 1},
      '{"op_1111",  4'b1111, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1, 1}
    };
    run_table(v);
  endtask

  task automatic test_muldiv();
    vec_t v[] = '{
      '{"mul",       4'b1011, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 1'b0, 1'b0, 33},
      '{"mulhu",     4'b1100, 32'hFFFFFFFF, 32'h2,        32'h1,        1'b0, 1'b0, 33},
      '{"mulhu_max", 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33},
      '{"divu",      4'b1101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33},
      '{"remu",      4'b1110, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33},
      '{"divu_max",  4'b1101, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0, 1'b0, 33},
      '{"remu_zero", 4'b1110, 32'd21,       32'd7,        32'd0,        1'b1, 1'b0, 33},
      '{"divu_by0",  4'b1101, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1},
      '{"remu_by0",  4'b1110, 32'd9,        32'd0,        32'd9,        1'b0, 1'b0, 1}
    };
    run_table(v);
  endtask

  task automatic test_backpressure();
    int hold_bad = 0;
    @(negedge clk);
    A = 32'd10; B = 32'd20; ALU_ctrl = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    A = 32'd1; B = 32'd1; ALU_ctrl = 4'b0001;  // in_valid stays high: must be ignored
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== 32'd30 || in_ready !== 1'b0 || zero !== 1'b0) hold_bad++;
      @(posedge clk); #1;
    end
    total++; if (hold_bad !== 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (result !== 32'd30) begin bad++; $display("FAIL bp_result: got %h want %h", result, 32'd30); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A = 32'd100; B = 32'd7; ALU_ctrl = 4'b1101; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_busy: got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_hs: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    total++; if (result !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_out: got r=%h z=%b o=%b want 0 1 0", result, zero, ovf); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_hold: got out_valid=%b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0; A = 32'd2; B = 32'd3; ALU_ctrl = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || result !== 32'd5) begin bad++; $display("FAIL post_rst_add: got v=%b r=%h want 1 %h", out_valid, result, 32'd5); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic z, o; int lat;
    run_op(4'b1011, 32'd12345, 32'd1000, r, z, o, lat);
    total++; if (r !== 32'd12345000 || lat !== 33) begin bad++; $display("FAIL b2b_mul: got r=%h lat=%0d want %h 33", r, lat, 32'd12345000); end
    run_op(4'b0001, 32'd3, 32'd5, r, z, o, lat);
    total++; if (r !== 32'hFFFFFFFE || o !== 1'b0 || lat !== 1) begin bad++; $display("FAIL b2b_sub: got r=%h o=%b lat=%0d want FFFFFFFE 0 1", r, o, lat); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALU_ctrl = '0;
    test_reset();
    test_single();
    test_muldiv();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
